multi_axis_step_generator: RTL

MULTI_AXIS_STEP_GENERATOR -- requirements
Module: multi_axis_step_generator

---
 rtl/multi_axis_step_generator_if.sv | 12 +
 rtl/multi_axis_step_generator.sv | 129 ++++++++++++
 2 files changed

// File: rtl/multi_axis_step_generator_if.sv
// Segment-word handshake between a motion planner and the step generator.
// The planner holds data_available and data steady until data_request pulses; that pulse means the word was taken.
interface multi_axis_step_generator_if #(
    parameter int SegmentBits = 83
);
    logic                   data_available;
    logic                   data_request;
    logic [SegmentBits-1:0] data;

    modport master (output data_available, output data, input data_request);
    modport slave  (input data_available, input data, output data_request);
endinterface

// File: rtl/multi_axis_step_generator.sv
// Multi-axis stepper pulse generator: consumes one segment word at a time and spreads each
// axis count evenly over the segment ticks using a per-axis Bresenham accumulator.
module multi_axis_step_generator #(
    parameter int Axes        = 3,
    parameter int CountBits   = 16,
    parameter int PeriodBits  = 16,
    parameter int PulseCycles = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    multi_axis_step_generator_if.slave  seg_if,
    output logic [Axes-1:0]             step_out,
    output logic [Axes-1:0]             dir_out,
    output logic                        busy,
    output logic                        underrun,
    output logic                        count_error,
    output logic [1:0]                  state_dbg
);
    localparam int SegmentBits = PeriodBits + CountBits + Axes + Axes * CountBits;
    localparam int PulseBits   = $clog2(PulseCycles + 1);
    localparam logic [PeriodBits-1:0] MinPeriod = PeriodBits'(2 * PulseCycles);

    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2} state_t;
    state_t state, state_nx;

    logic [SegmentBits-1:0] seg_q;
    logic                   data_request_q;
    logic [CountBits-1:0]   acc [Axes];
    logic [CountBits-1:0]   acc_nx [Axes];
    logic [CountBits-1:0]   tick_cnt;
    logic [PeriodBits-1:0]  period_cnt;
    logic [PulseBits-1:0]   pulse_cnt;
    logic [Axes-1:0]        step_mask;
    logic [Axes-1:0]        step_nx;
    logic [Axes-1:0]        over;

    logic [PeriodBits-1:0]  seg_period;
    logic [CountBits-1:0]   seg_ticks;
    logic [Axes-1:0]        seg_dir;
    logic [PeriodBits-1:0]  eff_period;
    logic                   tick;
    logic                   run_done;

    assign seg_period = seg_q[PeriodBits-1:0];
    assign seg_ticks  = seg_q[PeriodBits +: CountBits];
    assign seg_dir    = seg_q[PeriodBits+CountBits +: Axes];
    // Pulses must fit inside a tick, so very short periods are stretched.
    assign eff_period = (seg_period < MinPeriod) ? MinPeriod : seg_period;

    for (genvar i = 0; i < Axes; i++) begin : g_axis
        logic [CountBits-1:0] count_raw;
        logic [CountBits-1:0] count_clip;
        logic [CountBits:0]   sum;
        assign count_raw  = seg_q[PeriodBits+CountBits+Axes+i*CountBits +: CountBits];
        assign over[i]    = count_raw > seg_ticks;
        assign count_clip = over[i] ? seg_ticks : count_raw;
        assign sum        = {1'b0, acc[i]} + {1'b0, count_clip};
        assign step_nx[i] = sum >= {1'b0, seg_ticks};
        assign acc_nx[i]  = step_nx[i] ? CountBits'(sum - {1'b0, seg_ticks}) : sum[CountBits-1:0];
    end

    assign tick     = (state == RUN) && (tick_cnt != '0) && (period_cnt == PeriodBits'(1));
    assign run_done = (state == RUN) && (tick_cnt == '0) && (pulse_cnt <= PulseBits'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        underrun = 1'b0;
        case (state)
            IDLE: if (seg_if.data_available) state_nx = LOAD;
            LOAD: state_nx = (seg_ticks == '0) ? IDLE : RUN;
            RUN: begin
                if (run_done) begin
                    state_nx = IDLE;
                    underrun = !seg_if.data_available;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q          <= '0;
            data_request_q <= 1'b0;
            dir_out        <= '0;
            count_error    <= 1'b0;
            tick_cnt       <= '0;
            period_cnt     <= '0;
            pulse_cnt      <= '0;
            step_mask      <= '0;
            for (int i = 0; i < Axes; i++) acc[i] <= '0;
        end else begin
            data_request_q <= 1'b0;
            if (state == IDLE && seg_if.data_available) begin
                seg_q          <= seg_if.data;
                data_request_q <= 1'b1;
            end
            if (state == LOAD) begin
                if (|over) count_error <= 1'b1;
                if (seg_ticks != '0) begin
                    dir_out    <= seg_dir;
                    tick_cnt   <= seg_ticks;
                    period_cnt <= eff_period;
                    for (int i = 0; i < Axes; i++) acc[i] <= seg_ticks >> 1;
                end
            end
            if (tick) begin
                period_cnt <= eff_period;
                tick_cnt   <= tick_cnt - 1'b1;
                pulse_cnt  <= PulseBits'(PulseCycles);
                step_mask  <= step_nx;
                for (int i = 0; i < Axes; i++) acc[i] <= acc_nx[i];
            end else begin
                if (state == RUN && period_cnt != '0) period_cnt <= period_cnt - 1'b1;
                if (pulse_cnt != '0) pulse_cnt <= pulse_cnt - 1'b1;
            end
        end
    end

    assign seg_if.data_request = data_request_q;
    assign step_out  = (pulse_cnt != '0) ? step_mask : '0;
    assign busy      = (state == LOAD) || (state == RUN);
    assign state_dbg = state;
endmodule
